hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Generates forwarding selects for E-stage operands and per-stage enable/flush.
- Tracks outstanding loads in a register scoreboard and freezes the pipe on data-memory wait.
- Sequences multi-cycle flushes after a control redirect and counts stall cycles for performance monitoring.

---
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Rev 1.0
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] dec_rs1, dec_rs2;
  logic              dec_rs1_used, dec_rs2_used;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_valid, ex_is_load;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic              mem_we, wb_we;
  logic              ld_ret_valid;
  logic [REG_AW-1:0] ld_ret_rd;
  logic              dmem_req, dmem_ack;
  logic              redirect;
  logic [1:0]        fwd1_sel, fwd2_sel;
  logic              enb_f, enb_d, enb_e, enb_m, enb_w;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    input  ex_rs1, ex_rs2, ex_rd, ex_valid, ex_is_load,
    input  mem_rd, wb_rd, mem_we, wb_we,
    input  ld_ret_valid, ld_ret_rd, dmem_req, dmem_ack, redirect,
    output fwd1_sel, fwd2_sel,
    output enb_f, enb_d, enb_e, enb_m, enb_w,
    output flush_d, flush_e, flush_m, flush_w,
    output stall_cnt
  );

  modport master (
    output dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
    output ex_rs1, ex_rs2, ex_rd, ex_valid, ex_is_load,
    output mem_rd, wb_rd, mem_we, wb_we,
    output ld_ret_valid, ld_ret_rd, dmem_req, dmem_ack, redirect,
    input  fwd1_sel, fwd2_sel,
    input  enb_f, enb_d, enb_e, enb_m, enb_w,
    input  flush_d, flush_e, flush_m, flush_w,
    input  stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding, load scoreboard, stall/freeze/flush sequencing
// Rev 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MAX_OUTST   = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_ctrl_if.slave  bus
);
  localparam int NREGS = 2**REG_AW;
  localparam int OC_W  = $clog2(MAX_OUTST + 1);
  localparam int FC_W  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [OC_W-1:0] c_outst_max  = OC_W'(MAX_OUTST);
  localparam logic [FC_W-1:0] c_flush_init = FC_W'(FLUSH_DEPTH - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [FC_W-1:0]   r_fcnt, w_fcnt_nxt;
  logic              r_redirect_pend, w_rpend_nxt;
  logic [NREGS-1:0]  r_pending;
  logic [OC_W-1:0]   r_outst;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic       w_freeze, w_outst_full, w_load_use, w_lu1, w_lu2;
  logic       w_set, w_dec;
  logic [4:0] w_enb;    // {f,d,e,m,w}
  logic [3:0] w_flush;  // {d,e,m,w}
  logic [1:0] w_fwd1, w_fwd2;
  logic [NREGS-1:0] w_set_mask, w_clr_mask;

  always_comb begin
    w_fwd1 = 2'b00;
    if (bus.ex_rs1 != '0 && bus.ex_rs1 == bus.mem_rd && bus.mem_we)     w_fwd1 = 2'b01;
    else if (bus.ex_rs1 != '0 && bus.ex_rs1 == bus.wb_rd && bus.wb_we)  w_fwd1 = 2'b10;
    w_fwd2 = 2'b00;
    if (bus.ex_rs2 != '0 && bus.ex_rs2 == bus.mem_rd && bus.mem_we)     w_fwd2 = 2'b01;
    else if (bus.ex_rs2 != '0 && bus.ex_rs2 == bus.wb_rd && bus.wb_we)  w_fwd2 = 2'b10;
  end

  assign w_freeze     = bus.dmem_req && !bus.dmem_ack;
  assign w_outst_full = bus.ex_valid && bus.ex_is_load && (r_outst == c_outst_max);
  assign w_lu1 = bus.dec_rs1_used && (bus.dec_rs1 != '0) &&
                 (r_pending[bus.dec_rs1] ||
                  (bus.ex_valid && bus.ex_is_load && bus.ex_rd == bus.dec_rs1));
  assign w_lu2 = bus.dec_rs2_used && (bus.dec_rs2 != '0) &&
                 (r_pending[bus.dec_rs2] ||
                  (bus.ex_valid && bus.ex_is_load && bus.ex_rd == bus.dec_rs2));
  assign w_load_use = w_lu1 || w_lu2;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_rpend_nxt = r_redirect_pend;
    w_enb       = 5'b11111;
    w_flush     = 4'b0000;
    if (w_freeze) begin
      w_enb = 5'b00000;
      if (bus.redirect) w_rpend_nxt = 1'b1;
    end else begin
      w_rpend_nxt = 1'b0;
      if (bus.redirect || r_redirect_pend) begin
        w_flush = 4'b1100;
        if (FLUSH_DEPTH > 1) begin
          w_state_nxt = ST_REDIRECT;
          w_fcnt_nxt  = c_flush_init;
        end else begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = '0;
        end
      end else if (r_state == ST_REDIRECT) begin
        w_flush = 4'b1000;
        // the redirect cycle itself was the first flush, so leave once this one is counted
        if (r_fcnt <= FC_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt = r_fcnt - FC_W'(1);
        end
      end else if (w_outst_full) begin
        w_enb   = 5'b00011;
        w_flush = 4'b0010;
      end else if (w_load_use) begin
        w_enb   = 5'b00111;
        w_flush = 4'b0100;
      end
    end
    if (reset) begin
      w_enb   = 5'b00000;
      w_flush = 4'b1111;
    end
  end

  assign w_set      = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != '0) && w_enb[2];
  assign w_dec      = bus.ld_ret_valid && (r_outst != '0);
  assign w_set_mask = w_set ? (NREGS'(1) << bus.ex_rd) : '0;
  assign w_clr_mask = bus.ld_ret_valid ? (NREGS'(1) << bus.ld_ret_rd) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_fcnt          <= '0;
      r_redirect_pend <= 1'b0;
      r_pending       <= '0;
      r_outst         <= '0;
      r_stall_cnt     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_fcnt          <= w_fcnt_nxt;
      r_redirect_pend <= w_rpend_nxt;
      r_pending       <= (r_pending & ~w_clr_mask) | w_set_mask;
      case ({w_set, w_dec})
        2'b10:   if (r_outst != c_outst_max) r_outst <= r_outst + OC_W'(1);
        2'b01:   r_outst <= r_outst - OC_W'(1);
        default: r_outst <= r_outst;
      endcase
      if ((w_freeze || w_outst_full || w_load_use) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.fwd1_sel  = reset ? 2'b00 : w_fwd1;
  assign bus.fwd2_sel  = reset ? 2'b00 : w_fwd2;
  assign bus.enb_f     = w_enb[4];
  assign bus.enb_d     = w_enb[3];
  assign bus.enb_e     = w_enb[2];
  assign bus.enb_m     = w_enb[1];
  assign bus.enb_w     = w_enb[0];
  assign bus.flush_d   = w_flush[3];
  assign bus.flush_e   = w_flush[2];
  assign bus.flush_m   = w_flush[1];
  assign bus.flush_w   = w_flush[0];
  assign bus.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // {enb_f,enb_d,enb_e,enb_m,enb_w, flush_d,flush_e,flush_m,flush_w}
  localparam logic [8:0] c_run = 9'b11111_0000;
  localparam logic [8:0] c_frz = 9'b00000_0000;
  localparam logic [8:0] c_rdr = 9'b11111_1100;
  localparam logic [8:0] c_rdh = 9'b11111_1000;
  localparam logic [8:0] c_lu  = 9'b00111_0100;
  localparam logic [8:0] c_of  = 9'b00011_0010;
  localparam logic [8:0] c_rst = 9'b00000_1111;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) u_if ();

  hazard_ctrl #(
    .REG_AW(REG_AW), .MAX_OUTST(2), .FLUSH_DEPTH(2), .CNT_W(CNT_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  logic [8:0] w_ctl;
  assign w_ctl = {u_if.enb_f, u_if.enb_d, u_if.enb_e, u_if.enb_m, u_if.enb_w,
                  u_if.flush_d, u_if.flush_e, u_if.flush_m, u_if.flush_w};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    u_if.dec_rs1 = '0;  u_if.dec_rs2 = '0;
    u_if.dec_rs1_used = 1'b0; u_if.dec_rs2_used = 1'b0;
    u_if.ex_rs1 = '0;   u_if.ex_rs2 = '0;   u_if.ex_rd = '0;
    u_if.ex_valid = 1'b0; u_if.ex_is_load = 1'b0;
    u_if.mem_rd = '0;   u_if.wb_rd = '0;
    u_if.mem_we = 1'b0; u_if.wb_we = 1'b0;
    u_if.ld_ret_valid = 1'b0; u_if.ld_ret_rd = '0;
    u_if.dmem_req = 1'b0; u_if.dmem_ack = 1'b0;
    u_if.redirect = 1'b0;
  endtask

  task automatic ex_load(input logic [REG_AW-1:0] rd);
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b1; u_if.ex_rd = rd;
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    #1;
    check_eq("reset_ctl", 32'(w_ctl), 32'(c_rst));
    check_eq("reset_cnt", 32'(u_if.stall_cnt), 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("run_idle", 32'(w_ctl), 32'(c_run));

    // forwarding
    u_if.ex_rs1 = 5'd3; u_if.mem_rd = 5'd3; u_if.mem_we = 1'b1;
    u_if.wb_rd = 5'd3;  u_if.wb_we = 1'b1;  u_if.ex_rs2 = 5'd3;
    #1;
    check_eq("fwd1_mem", 32'(u_if.fwd1_sel), 32'd1);
    check_eq("fwd2_mem", 32'(u_if.fwd2_sel), 32'd1);
    u_if.mem_we = 1'b0;
    #1;
    check_eq("fwd1_wb", 32'(u_if.fwd1_sel), 32'd2);
    u_if.ex_rs1 = 5'd0;
    #1;
    check_eq("fwd1_x0", 32'(u_if.fwd1_sel), 32'd0);
    u_if.wb_we = 1'b0;
    #1;
    check_eq("fwd2_none", 32'(u_if.fwd2_sel), 32'd0);
    clr_in();

    // unused source or x0 never stalls
    ex_load(5'd5); u_if.dec_rs2 = 5'd5;
    #1;
    check_eq("lu_unused", 32'(w_ctl), 32'(c_run));
    ex_load(5'd0); u_if.dec_rs1 = 5'd0; u_if.dec_rs1_used = 1'b1;
    #1;
    check_eq("lu_x0", 32'(w_ctl), 32'(c_run));
    clr_in();

    // load-use on x5, then held by the scoreboard until the return
    ex_load(5'd5); u_if.dec_rs2 = 5'd5; u_if.dec_rs2_used = 1'b1;
    #1;
    check_eq("lu_ex", 32'(w_ctl), 32'(c_lu));
    tick();
    check_eq("lu_cnt1", 32'(u_if.stall_cnt), 32'd1);
    u_if.ex_valid = 1'b0; u_if.ex_is_load = 1'b0; u_if.ex_rd = '0;
    #1;
    check_eq("lu_pend", 32'(w_ctl), 32'(c_lu));
    tick();
    u_if.ld_ret_valid = 1'b1; u_if.ld_ret_rd = 5'd5;
    #1;
    check_eq("lu_ret_cyc", 32'(w_ctl), 32'(c_lu));
    tick();
    u_if.ld_ret_valid = 1'b0;
    #1;
    check_eq("lu_release", 32'(w_ctl), 32'(c_run));
    check_eq("lu_cnt3", 32'(u_if.stall_cnt), 32'd3);
    clr_in();

    // outstanding limit of two
    ex_load(5'd6);
    #1;
    check_eq("of_ld1", 32'(w_ctl), 32'(c_run));
    tick();
    ex_load(5'd7);
    #1;
    check_eq("of_ld2", 32'(w_ctl), 32'(c_run));
    tick();
    ex_load(5'd8);
    #1;
    check_eq("of_full", 32'(w_ctl), 32'(c_of));
    tick();
    check_eq("of_cnt4", 32'(u_if.stall_cnt), 32'd4);
    u_if.ld_ret_valid = 1'b1; u_if.ld_ret_rd = 5'd6;
    #1;
    check_eq("of_full_ret", 32'(w_ctl), 32'(c_of));
    tick();
    u_if.ld_ret_valid = 1'b0;
    #1;
    check_eq("of_issue3", 32'(w_ctl), 32'(c_run));
    tick();
    clr_in();
    u_if.dec_rs1 = 5'd8; u_if.dec_rs1_used = 1'b1;
    #1;
    check_eq("of_x8_pend", 32'(w_ctl), 32'(c_lu));
    clr_in();
    u_if.ld_ret_valid = 1'b1; u_if.ld_ret_rd = 5'd7;
    tick();
    u_if.ld_ret_rd = 5'd8;
    tick();
    clr_in();
    u_if.dec_rs1 = 5'd8; u_if.dec_rs1_used = 1'b1;
    u_if.dec_rs2 = 5'd6; u_if.dec_rs2_used = 1'b1;
    #1;
    check_eq("of_drained", 32'(w_ctl), 32'(c_run));
    check_eq("of_cnt5", 32'(u_if.stall_cnt), 32'd5);
    clr_in();

    // freeze with a redirect arriving in its first cycle
    u_if.dmem_req = 1'b1; u_if.redirect = 1'b1;
    #1;
    check_eq("frz_c1", 32'(w_ctl), 32'(c_frz));
    tick();
    u_if.redirect = 1'b0;
    #1;
    check_eq("frz_c2", 32'(w_ctl), 32'(c_frz));
    tick();
    check_eq("frz_c3", 32'(w_ctl), 32'(c_frz));
    tick();
    u_if.dmem_ack = 1'b1;
    #1;
    check_eq("frz_redir", 32'(w_ctl), 32'(c_rdr));
    tick();
    clr_in();
    #1;
    check_eq("frz_hold", 32'(w_ctl), 32'(c_rdh));
    tick();
    check_eq("frz_done", 32'(w_ctl), 32'(c_run));
    check_eq("frz_cnt8", 32'(u_if.stall_cnt), 32'd8);

    // back-to-back redirects
    u_if.redirect = 1'b1;
    #1;
    check_eq("b2b_c0", 32'(w_ctl), 32'(c_rdr));
    tick();
    check_eq("b2b_c1", 32'(w_ctl), 32'(c_rdr));
    tick();
    u_if.redirect = 1'b0;
    #1;
    check_eq("b2b_c2", 32'(w_ctl), 32'(c_rdh));
    tick();
    check_eq("b2b_c3", 32'(w_ctl), 32'(c_run));

    // freeze inside the flush window holds the count
    u_if.redirect = 1'b1;
    tick();
    u_if.redirect = 1'b0; u_if.dmem_req = 1'b1;
    #1;
    check_eq("rfz_frz", 32'(w_ctl), 32'(c_frz));
    tick();
    u_if.dmem_req = 1'b0;
    #1;
    check_eq("rfz_hold", 32'(w_ctl), 32'(c_rdh));
    tick();
    check_eq("rfz_done", 32'(w_ctl), 32'(c_run));
    check_eq("rfz_cnt9", 32'(u_if.stall_cnt), 32'd9);

    // counter saturation
    u_if.dmem_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("cnt_sat", 32'(u_if.stall_cnt), 32'hF);
    clr_in();

    // reset while in REDIRECT with x9 pending
    ex_load(5'd9);
    tick();
    clr_in();
    u_if.redirect = 1'b1;
    tick();
    clr_in();
    u_if.ex_rs1 = 5'd3; u_if.mem_rd = 5'd3; u_if.mem_we = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_ctl", 32'(w_ctl), 32'(c_rst));
    check_eq("rst_mid_cnt", 32'(u_if.stall_cnt), 32'd0);
    check_eq("rst_mid_fwd", 32'(u_if.fwd1_sel), 32'd0);
    tick(); tick();
    reset = 1'b0;
    clr_in();
    u_if.dec_rs1 = 5'd9; u_if.dec_rs1_used = 1'b1;
    #1;
    check_eq("rst_post_ctl", 32'(w_ctl), 32'(c_run));
    tick();
    check_eq("rst_post_cnt", 32'(u_if.stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
